block_reclaim_ctrl: RTL and testbench
=====================================

BLOCK_RECLAIM_CTRL -- requirements
Module: block_reclaim_ctrl

Interface
REQ-001 SHALL have parameter BLOCKS, default 64, number of flash erase blocks; IDX_W = clog2(BLOCKS).
REQ-002 SHALL have parameter ERASE_W, default 16, width of each per-block erase counter.
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum WAIT cycles before the watchdog fires (used only with RECLAIM_TIMEOUT_EN).
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: alloc_valid  in  1  allocate block (single-cycle strobe); alloc_block  in  IDX_W  block being allocated.
REQ-006 SHALL have ports: reclaim_valid  in  1  erase/return request; reclaim_ready  out  1  request accepted when both high; reclaim_block  in  IDX_W  block to reclaim.
REQ-007 SHALL have ports: erase_req  out  1  flash erase command; erase_addr  out  IDX_W  target block; erase_ack  in  1  command taken; erase_done  in  1  erase passed; erase_fail  in  1  erase failed.
REQ-008 SHALL have ports: erase_count_flat  out  BLOCKS*ERASE_W  block i at [i*ERASE_W +: ERASE_W]; free_bitmap  out  BLOCKS  1 = free; bad_bitmap  out  BLOCKS  1 = retired.
REQ-009 SHALL have ports: reclaim_done  out  1  completion pulse; reclaim_status  out  2  00 OK, 01 FAIL, 10 SKIP, 11 TIMEOUT; busy  out  1  state != IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, UPDATE; reclaim_ready = 1 only in IDLE.
REQ-011 On accept in IDLE: latch reclaim_block; if the block's free or bad bit is set, go to UPDATE with status SKIP and no flash operation; otherwise go to ISSUE.
REQ-012 In ISSUE, erase_req = 1 and erase_addr = latched block, held stable until erase_ack; go to WAIT in the cycle after ack.
REQ-013 In WAIT: erase_done -> UPDATE with status OK; erase_fail -> UPDATE with status FAIL; if both assert in the same cycle, FAIL wins; done/fail outside WAIT are ignored.
REQ-014 UPDATE lasts one cycle, then returns to IDLE. On OK: increment the block's count, saturating at all-ones, and set its free bit. On FAIL/TIMEOUT: increment the count (saturating), set its bad bit, leave the free bit 0. On SKIP: no state change.
REQ-015 reclaim_done SHALL be a one-cycle registered pulse, with reclaim_status valid in that cycle, in the first cycle the UPDATE results are visible on the outputs.
REQ-016 alloc_valid SHALL clear free_bitmap[alloc_block] at the next edge only if that bit is currently 1 and the block is not bad; otherwise it is ignored. It is accepted in any FSM state.
REQ-017 If an alloc and an UPDATE free-set target the same block in the same cycle, the UPDATE set wins (alloc saw the bit as 0).
REQ-018 Minimum reclaim latency: accept -> reclaim_done 4 cycles with zero-delay ack and done; SKIP takes 2 cycles.
REQ-019 alloc_block or reclaim_block values >= BLOCKS SHALL be ignored (alloc) or return SKIP (reclaim).

Reset
REQ-020 While rst is high at an edge: FSM -> IDLE; all counts = 0; free_bitmap = all ones; bad_bitmap = 0; erase_req, reclaim_done, reclaim_status = 0.
REQ-021 Reset during ISSUE/WAIT SHALL abandon the operation with no reclaim_done pulse; erase_req drops at the same edge.

Configuration
REQ-022 Macro RECLAIM_TIMEOUT_EN: when defined, a counter clears on WAIT entry; if it reaches TIMEOUT with no done/fail, the FSM goes to UPDATE with status TIMEOUT. When undefined, WAIT waits indefinitely and status 11 is never produced.

Structure
REQ-023 Shared package flash_ctrl_pkg SHALL hold the FSM state enum, the 2-bit reclaim status codes, and the clog2-based index-width helper.
REQ-024 The watchdog SHALL be a sub-module reclaim_watchdog (start, stop, expired), instantiated only under RECLAIM_TIMEOUT_EN.

Verification
REQ-025 After reset, reclaim block 5 -> SKIP after 2 cycles, count[5] = 0, no erase_req.
REQ-026 Alloc 5, reclaim 5, ack and done immediately -> erase_addr = 5, reclaim_done 4 cycles after accept, status 00, count[5] = 1, free[5] = 1.
REQ-027 Alloc 9, reclaim 9, assert erase_done and erase_fail together -> status 01, bad[9] = 1, free[9] = 0; a later alloc 9 is ignored.
REQ-028 Preload count[3] = 0xFFFF via 65535 reclaim cycles (or force), then another OK reclaim -> count stays 0xFFFF.
REQ-029 With RECLAIM_TIMEOUT_EN and TIMEOUT = 8, no done -> status 11 on the 9th WAIT cycle, bad set; reset asserted in WAIT instead -> no done pulse and outputs at reset values.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// flash_ctrl_pkg
// Shared definitions for the flash block reclaim path:
//   - reclaim_state_e  : reclaim FSM states (IDLE, ISSUE, WAIT, UPDATE)
//   - reclaim_status_e : 2-bit completion codes reported with reclaim_done
//   - idx_width()      : clog2-based index width helper (never narrower than 1)
// -----------------------------------------------------------------------------
package flash_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_WAIT   = 2'b10,
        ST_UPDATE = 2'b11
    } reclaim_state_e;

    typedef enum logic [1:0] {
        RS_OK      = 2'b00,
        RS_FAIL    = 2'b01,
        RS_SKIP    = 2'b10,
        RS_TIMEOUT = 2'b11
    } reclaim_status_e;

    // Width of an index able to address n entries; a single-entry table
    // still gets a 1-bit index so port widths never collapse to zero.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/reclaim_watchdog.sv
// -----------------------------------------------------------------------------
// reclaim_watchdog
// Counts cycles spent waiting for an erase result and flags when the
// configured limit is reached.
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset
//   start   in  clear the counter and begin counting (entry into WAIT)
//   stop    in  halt counting (FSM not in WAIT); start has priority
//   expired out counter has reached TIMEOUT while running
// -----------------------------------------------------------------------------
module reclaim_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             running_r;

    // Wait-cycle counter: value k-1 in the k-th WAIT cycle, parks at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            running_r <= 1'b0;
        end else if (start) begin
            cnt_r     <= {CNT_W{1'b0}};
            running_r <= 1'b1;
        end else if (stop) begin
            running_r <= 1'b0;
        end else if (running_r && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + ONE;
        end
    end

    // Pure decode of registered state, so it adds no combinational path
    // from the FSM inputs.
    assign expired = running_r && (cnt_r == LIMIT);

endmodule

// File: rtl/block_reclaim_ctrl.sv
// -----------------------------------------------------------------------------
// block_reclaim_ctrl
// Tracks free / retired (bad) flash erase blocks and per-block erase counts,
// and sequences one erase per reclaim request.
//
// Optional build macro: RECLAIM_TIMEOUT_EN
//   defined   -> a reclaim_watchdog aborts WAIT after TIMEOUT cycles with
//                status TIMEOUT and the block is retired
//   undefined -> WAIT waits indefinitely for erase_done / erase_fail
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_valid/alloc_block  strobe: mark a free, non-bad block as in use
//   reclaim_valid/_ready     request handshake (ready only in IDLE)
//   reclaim_block            block to erase and return to the free pool
//   erase_req/erase_addr     erase command, held until erase_ack
//   erase_ack                command taken by the flash side
//   erase_done/erase_fail    erase result (only sampled in WAIT)
//   erase_count_flat         block i count at [i*ERASE_W +: ERASE_W]
//   free_bitmap/bad_bitmap   1 = free / 1 = retired
//   reclaim_done/_status     one-cycle completion pulse and its code
//   busy                     FSM not in IDLE
// -----------------------------------------------------------------------------
module block_reclaim_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter  int BLOCKS  = 64,
    parameter  int ERASE_W = 16,
    parameter  int TIMEOUT = 4096,
    localparam int IDX_W   = idx_width(BLOCKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [IDX_W-1:0]           alloc_block,
    input  logic                       reclaim_valid,
    output logic                       reclaim_ready,
    input  logic [IDX_W-1:0]           reclaim_block,
    output logic                       erase_req,
    output logic [IDX_W-1:0]           erase_addr,
    input  logic                       erase_ack,
    input  logic                       erase_done,
    input  logic                       erase_fail,
    output logic [BLOCKS*ERASE_W-1:0]  erase_count_flat,
    output logic [BLOCKS-1:0]          free_bitmap,
    output logic [BLOCKS-1:0]          bad_bitmap,
    output logic                       reclaim_done,
    output logic [1:0]                 reclaim_status,
    output logic                       busy
);

    localparam logic [IDX_W:0] BLOCKS_L = (IDX_W + 1)'(BLOCKS);

    reclaim_state_e    state_r;
    reclaim_state_e    next_state_s;
    reclaim_status_e   status_r;
    reclaim_status_e   next_status_s;
    logic [IDX_W-1:0]  blk_r;
    logic              erase_req_r;
    logic              reclaim_done_r;
    logic [1:0]        reclaim_status_r;
    logic [BLOCKS-1:0] free_r;
    logic [BLOCKS-1:0] bad_r;
    logic [ERASE_W-1:0] count_r [BLOCKS];
    logic              req_skip_s;
    logic              alloc_hit_s;
    logic              wd_expired_s;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < BLOCKS_L);
    endfunction

    function automatic logic [ERASE_W-1:0] sat_inc(input logic [ERASE_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(ERASE_W-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef RECLAIM_TIMEOUT_EN
    logic wd_start_s;
    logic wd_stop_s;

    assign wd_start_s = (state_r == ST_ISSUE) && erase_ack;
    assign wd_stop_s  = (state_r != ST_WAIT);

    reclaim_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (wd_start_s),
        .stop    (wd_stop_s),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // A reclaim needs no flash work if the block is out of range, already free or retired.
    always_comb begin
        req_skip_s = 1'b1;
        if (in_range(reclaim_block)) begin
            req_skip_s = free_r[reclaim_block] | bad_r[reclaim_block];
        end else begin
            req_skip_s = 1'b1;
        end
    end

    // An allocation only takes effect on an in-range, free, non-retired block.
    always_comb begin
        alloc_hit_s = 1'b0;
        if (alloc_valid && in_range(alloc_block)) begin
            alloc_hit_s = free_r[alloc_block] & ~bad_r[alloc_block];
        end else begin
            alloc_hit_s = 1'b0;
        end
    end

    // FSM next-state and status selection.
    always_comb begin
        next_state_s  = state_r;
        next_status_s = status_r;
        case (state_r)
            ST_IDLE: begin
                if (reclaim_valid && req_skip_s) begin
                    next_state_s  = ST_UPDATE;
                    next_status_s = RS_SKIP;
                end else if (reclaim_valid) begin
                    next_state_s  = ST_ISSUE;
                    next_status_s = RS_OK;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (erase_ack) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // fail outranks done when both arrive together
                if (erase_fail) begin
                    next_state_s  = ST_UPDATE;
                    next_status_s = RS_FAIL;
                end else if (erase_done) begin
                    next_state_s  = ST_UPDATE;
                    next_status_s = RS_OK;
                end else if (wd_expired_s) begin
                    next_state_s  = ST_UPDATE;
                    next_status_s = RS_TIMEOUT;
                end else begin
                    next_state_s  = ST_WAIT;
                end
            end
            ST_UPDATE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s  = ST_IDLE;
                next_status_s = RS_OK;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, command/completion outputs and block bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_r            <= {IDX_W{1'b0}};
            status_r         <= RS_OK;
            erase_req_r      <= 1'b0;
            reclaim_done_r   <= 1'b0;
            reclaim_status_r <= 2'b00;
            free_r           <= {BLOCKS{1'b1}};
            bad_r            <= {BLOCKS{1'b0}};
            for (int i = 0; i < BLOCKS; i++) begin
                count_r[i] <= {ERASE_W{1'b0}};
            end
        end else begin
            status_r    <= next_status_s;
            erase_req_r <= (next_state_s == ST_ISSUE);
            if ((state_r == ST_IDLE) && reclaim_valid) begin
                blk_r <= reclaim_block;
            end
            // Results commit at the edge leaving UPDATE, so the done pulse
            // lands in the same cycle the new bitmaps/counts appear.
            reclaim_done_r <= (state_r == ST_UPDATE);
            if (state_r == ST_UPDATE) begin
                reclaim_status_r <= status_r;
            end
            if (alloc_hit_s) begin
                free_r[alloc_block] <= 1'b0;
            end
            // Written after the alloc clear so a same-block free-set wins.
            if (state_r == ST_UPDATE) begin
                case (status_r)
                    RS_OK: begin
                        count_r[blk_r] <= sat_inc(count_r[blk_r]);
                        free_r[blk_r]  <= 1'b1;
                    end
                    RS_FAIL, RS_TIMEOUT: begin
                        count_r[blk_r] <= sat_inc(count_r[blk_r]);
                        bad_r[blk_r]   <= 1'b1;
                    end
                    default: begin
                        // SKIP leaves every block untouched
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < BLOCKS; g++) begin : g_count_flat
        assign erase_count_flat[g*ERASE_W +: ERASE_W] = count_r[g];
    end

    assign reclaim_ready  = (state_r == ST_IDLE);
    assign busy           = (state_r != ST_IDLE);
    assign erase_req      = erase_req_r;
    assign erase_addr     = blk_r;
    assign free_bitmap    = free_r;
    assign bad_bitmap     = bad_r;
    assign reclaim_done   = reclaim_done_r;
    assign reclaim_status = reclaim_status_r;

endmodule

// File: tb/tb_block_reclaim_ctrl.sv
module tb_block_reclaim_ctrl;

    localparam int BLOCKS = 12;
    localparam int EW     = 8;
    localparam int TO     = 8;
    localparam int IW     = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   alloc_valid = 1'b0;
    logic [IW-1:0]          alloc_block = '0;
    logic                   reclaim_valid = 1'b0;
    logic                   reclaim_ready;
    logic [IW-1:0]          reclaim_block = '0;
    logic                   erase_req;
    logic [IW-1:0]          erase_addr;
    logic                   erase_ack = 1'b0;
    logic                   erase_done = 1'b0;
    logic                   erase_fail = 1'b0;
    logic [BLOCKS*EW-1:0]   erase_count_flat;
    logic [BLOCKS-1:0]      free_bitmap;
    logic [BLOCKS-1:0]      bad_bitmap;
    logic                   reclaim_done;
    logic [1:0]             reclaim_status;
    logic                   busy;

    block_reclaim_ctrl #(
        .BLOCKS  (BLOCKS),
        .ERASE_W (EW),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_block      (alloc_block),
        .reclaim_valid    (reclaim_valid),
        .reclaim_ready    (reclaim_ready),
        .reclaim_block    (reclaim_block),
        .erase_req        (erase_req),
        .erase_addr       (erase_addr),
        .erase_ack        (erase_ack),
        .erase_done       (erase_done),
        .erase_fail       (erase_fail),
        .erase_count_flat (erase_count_flat),
        .free_bitmap      (free_bitmap),
        .bad_bitmap       (bad_bitmap),
        .reclaim_done     (reclaim_done),
        .reclaim_status   (reclaim_status),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            blk;
        logic [1:0]    st;
        logic [EW-1:0] cnt;
        logic          fr;
        logic          bd;
    } sb_t;

    sb_t           sb_q[$];
    sb_t           mon_e;
    int            total_cnt = 0;
    int            bad_cnt   = 0;
    logic [BLOCKS-1:0] m_free;
    logic [BLOCKS-1:0] m_bad;
    logic [EW-1:0]     m_cnt [BLOCKS];

    function automatic logic [EW-1:0] cnt_of(input int b);
        return erase_count_flat[b*EW +: EW];
    endfunction

    function automatic logic [EW-1:0] sat1(input logic [EW-1:0] v);
        if (v == {EW{1'b1}}) return v;
        return v + 1'b1;
    endfunction

    task automatic model_reset();
        m_free = '1;
        m_bad  = '0;
        for (int i = 0; i < BLOCKS; i++) m_cnt[i] = '0;
    endtask

    // Scoreboard consumer: every completion pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && reclaim_done) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                bad_cnt++;
                $display("FAIL sb_unexpected_done: got status=%0d, required no pulse", reclaim_status);
            end else begin
                mon_e = sb_q.pop_front();
                if (reclaim_status !== mon_e.st) begin
                    bad_cnt++;
                    $display("FAIL sb_status blk=%0d: got=%0d required=%0d", mon_e.blk, reclaim_status, mon_e.st);
                end
                if (mon_e.blk < BLOCKS) begin
                    total_cnt += 3;
                    if (cnt_of(mon_e.blk) !== mon_e.cnt) begin
                        bad_cnt++;
                        $display("FAIL sb_count blk=%0d: got=%0d required=%0d", mon_e.blk, cnt_of(mon_e.blk), mon_e.cnt);
                    end
                    if (free_bitmap[mon_e.blk] !== mon_e.fr) begin
                        bad_cnt++;
                        $display("FAIL sb_free blk=%0d: got=%0b required=%0b", mon_e.blk, free_bitmap[mon_e.blk], mon_e.fr);
                    end
                    if (bad_bitmap[mon_e.blk] !== mon_e.bd) begin
                        bad_cnt++;
                        $display("FAIL sb_bad blk=%0d: got=%0b required=%0b", mon_e.blk, bad_bitmap[mon_e.blk], mon_e.bd);
                    end
                end
            end
        end
    end

    task automatic do_alloc(input int blk);
        @(posedge clk); #1;
        alloc_valid = 1'b1;
        alloc_block = blk[IW-1:0];
        @(posedge clk); #1;
        alloc_valid = 1'b0;
        if (blk < BLOCKS && m_free[blk] && !m_bad[blk]) m_free[blk] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (free_bitmap !== m_free) begin
            bad_cnt++;
            $display("FAIL alloc_free blk=%0d: got=%h required=%h", blk, free_bitmap, m_free);
        end
    endtask

    // One reclaim: pushes the expectation at accept, drives the flash side,
    // and checks the accept-to-done latency (accept edge counted as 1).
    task automatic do_reclaim(input int blk, input int ack_dly, input int done_dly,
                              input bit dn, input bit fl, input bit spurious, input bit alloc_upd);
        sb_t        ent;
        bit         skip;
        bit         got;
        int         e;
        int         exp_lat;
        logic [1:0] st;
        if (blk >= BLOCKS) skip = 1'b1;
        else skip = m_free[blk] | m_bad[blk];
        if (skip)    st = 2'b10;
        else if (fl) st = 2'b01;
        else if (dn) st = 2'b00;
        else         st = 2'b11;
        if (!skip) begin
            m_cnt[blk] = sat1(m_cnt[blk]);
            if (st == 2'b00) m_free[blk] = 1'b1;
            else m_bad[blk] = 1'b1;
        end
        ent.blk = blk;
        ent.st  = st;
        if (blk < BLOCKS) begin
            ent.cnt = m_cnt[blk]; ent.fr = m_free[blk]; ent.bd = m_bad[blk];
        end else begin
            ent.cnt = '0; ent.fr = 1'b0; ent.bd = 1'b0;
        end
        if (skip) exp_lat = 2;
        else if (dn || fl) exp_lat = 4 + ack_dly + done_dly;
        else exp_lat = 4 + ack_dly + TO;

        @(posedge clk); #1;
        reclaim_valid = 1'b1;
        reclaim_block = blk[IW-1:0];
        @(negedge clk);
        total_cnt++;
        if (reclaim_ready !== 1'b1) begin
            bad_cnt++;
            $display("FAIL ready_idle blk=%0d: got=%b required=1", blk, reclaim_ready);
        end
        @(posedge clk);
        sb_q.push_back(ent);
        #1;
        reclaim_valid = 1'b0;
        e = 1;
        if (skip) begin
            @(negedge clk);
            total_cnt++;
            if (erase_req !== 1'b0) begin
                bad_cnt++;
                $display("FAIL skip_no_erase blk=%0d: got=%b required=0", blk, erase_req);
            end
            @(posedge clk); #1; e++;
        end else begin
            for (int i = 0; i < ack_dly; i++) begin
                erase_done = spurious;
                erase_fail = spurious;
                @(negedge clk);
                total_cnt++;
                if (erase_req !== 1'b1 || erase_addr !== blk[IW-1:0]) begin
                    bad_cnt++;
                    $display("FAIL issue_hold blk=%0d: got req=%b addr=%0d required req=1 addr=%0d", blk, erase_req, erase_addr, blk);
                end
                @(posedge clk); #1; e++;
            end
            erase_done = 1'b0;
            erase_fail = 1'b0;
            erase_ack  = 1'b1;
            @(negedge clk);
            total_cnt++;
            if (erase_req !== 1'b1 || erase_addr !== blk[IW-1:0] || reclaim_ready !== 1'b0 || busy !== 1'b1) begin
                bad_cnt++;
                $display("FAIL issue blk=%0d: got req=%b addr=%0d ready=%b busy=%b required 1,%0d,0,1", blk, erase_req, erase_addr, reclaim_ready, busy, blk);
            end
            @(posedge clk); #1; e++;
            erase_ack = 1'b0;
            if (dn || fl) begin
                for (int i = 0; i < done_dly; i++) begin
                    @(posedge clk); #1; e++;
                end
                erase_done = dn;
                erase_fail = fl;
                @(posedge clk); #1; e++;
                erase_done = 1'b0;
                erase_fail = 1'b0;
                if (alloc_upd) begin
                    alloc_valid = 1'b1;
                    alloc_block = blk[IW-1:0];
                    @(posedge clk); #1; e++;
                    alloc_valid = 1'b0;
                end
            end
        end
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (reclaim_done) got = 1'b1;
            else begin
                @(posedge clk); #1; e++;
            end
        end
        total_cnt++;
        if (!got) begin
            bad_cnt++;
            $display("FAIL done_timeout blk=%0d: got no reclaim_done, required latency %0d", blk, exp_lat);
        end else if (e != exp_lat) begin
            bad_cnt++;
            $display("FAIL latency blk=%0d: got=%0d required=%0d", blk, e, exp_lat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total_cnt += 8;
        if (free_bitmap !== {BLOCKS{1'b1}}) begin bad_cnt++; $display("FAIL %s_free: got=%h required=all ones", tag, free_bitmap); end
        if (bad_bitmap !== '0) begin bad_cnt++; $display("FAIL %s_bad: got=%h required=0", tag, bad_bitmap); end
        if (erase_count_flat !== '0) begin bad_cnt++; $display("FAIL %s_counts: got=%h required=0", tag, erase_count_flat); end
        if (erase_req !== 1'b0) begin bad_cnt++; $display("FAIL %s_erase_req: got=%b required=0", tag, erase_req); end
        if (reclaim_done !== 1'b0) begin bad_cnt++; $display("FAIL %s_done: got=%b required=0", tag, reclaim_done); end
        if (reclaim_status !== 2'b00) begin bad_cnt++; $display("FAIL %s_status: got=%0d required=0", tag, reclaim_status); end
        if (busy !== 1'b0) begin bad_cnt++; $display("FAIL %s_busy: got=%b required=0", tag, busy); end
        if (reclaim_ready !== 1'b1) begin bad_cnt++; $display("FAIL %s_ready: got=%b required=1", tag, reclaim_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
    endtask

    task automatic test_skip();
        do_reclaim(5, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ok();
        do_alloc(5);
        do_reclaim(5, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fail();
        do_alloc(9);
        do_reclaim(9, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_alloc(9);
        total_cnt++;
        if (bad_bitmap !== m_bad) begin
            bad_cnt++;
            $display("FAIL fail_bad_map: got=%h required=%h", bad_bitmap, m_bad);
        end
        do_reclaim(9, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_delays();
        do_alloc(7);
        do_reclaim(7, 3, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_out_of_range();
        do_reclaim(13, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_alloc(13);
    endtask

    task automatic test_collision();
        do_alloc(2);
        do_reclaim(2, 1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < (1 << EW); i++) begin
            do_alloc(3);
            do_reclaim(3, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        total_cnt++;
        if (cnt_of(3) !== {EW{1'b1}}) begin
            bad_cnt++;
            $display("FAIL saturate: got=%0d required=%0d", cnt_of(3), {EW{1'b1}});
        end
    endtask

    task automatic test_back_to_back();
        int blks[4] = '{0, 1, 4, 11};
        foreach (blks[k]) do_alloc(blks[k]);
        foreach (blks[k]) do_reclaim(blks[k], $urandom_range(0, 2), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef RECLAIM_TIMEOUT_EN
    task automatic test_timeout();
        do_alloc(4);
        do_reclaim(4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_abort();
        do_alloc(6);
        @(posedge clk); #1;
        reclaim_valid = 1'b1;
        reclaim_block = 4'd6;
        @(posedge clk); #1;
        reclaim_valid = 1'b0;
        erase_ack = 1'b1;
        @(posedge clk); #1;
        erase_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) begin
            bad_cnt++;
            $display("FAIL abort_busy: got=%b required=1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (12) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish before 1000000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_skip();
        test_ok();
        test_fail();
        test_delays();
        test_out_of_range();
        test_collision();
        test_back_to_back();
        test_saturate();
`ifdef RECLAIM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_abort();
        total_cnt++;
        if (sb_q.size() != 0) begin
            bad_cnt++;
            $display("FAIL sb_leftover: got=%0d pending required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
